// File: rtl/lvds_8b10b_pkg.sv
// Shared constants, payload type and code-table helpers for the 8b/10b encoder.
// Symbol bit order: bit0..9 = a,b,c,d,e,i,f,g,h,j.
package lvds_8b10b_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned SYM_W  = 10;

  // Control byte values {HGF,EDCBA}
  localparam logic [7:0] K28_0 = 8'h1C;
  localparam logic [7:0] K28_1 = 8'h3C;
  localparam logic [7:0] K28_2 = 8'h5C;
  localparam logic [7:0] K28_3 = 8'h7C;
  localparam logic [7:0] K28_4 = 8'h9C;
  localparam logic [7:0] K28_5 = 8'hBC;
  localparam logic [7:0] K28_6 = 8'hDC;
  localparam logic [7:0] K28_7 = 8'hFC;
  localparam logic [7:0] K23_7 = 8'hF7;
  localparam logic [7:0] K27_7 = 8'hFB;
  localparam logic [7:0] K29_7 = 8'hFD;
  localparam logic [7:0] K30_7 = 8'hFE;

  // K28.5 in both disparities; RD+ form is the reset value
  localparam logic [SYM_W-1:0] K28_5_RDN = 10'h17C;
  localparam logic [SYM_W-1:0] K28_5_RDP = 10'h283;

  // Position of each code bit within a symbol
  localparam int unsigned BIT_A = 0;
  localparam int unsigned BIT_B = 1;
  localparam int unsigned BIT_C = 2;
  localparam int unsigned BIT_D = 3;
  localparam int unsigned BIT_E = 4;
  localparam int unsigned BIT_I = 5;
  localparam int unsigned BIT_F = 6;
  localparam int unsigned BIT_G = 7;
  localparam int unsigned BIT_H = 8;
  localparam int unsigned BIT_J = 9;

  typedef struct packed {
    logic              k;
    logic [BYTE_W-1:0] data;
  } enc_byte_t;

  // True for the twelve control codes the line code defines
  function automatic logic k_legal(input logic [7:0] b);
    return (b[4:0] == 5'd28) ||
           ((b[7:5] == 3'd7) && ((b[4:0] == 5'd23) || (b[4:0] == 5'd27) ||
                                 (b[4:0] == 5'd29) || (b[4:0] == 5'd30)));
  endfunction

  // 5b/6b RD- form, abcdei packed MSB-first
  function automatic logic [5:0] enc6_rdn(input logic [4:0] x);
    case (x)
      5'd0:  return 6'b100111;  5'd1:  return 6'b011101;
      5'd2:  return 6'b101101;  5'd3:  return 6'b110001;
      5'd4:  return 6'b110101;  5'd5:  return 6'b101001;
      5'd6:  return 6'b011001;  5'd7:  return 6'b111000;
      5'd8:  return 6'b111001;  5'd9:  return 6'b100101;
      5'd10: return 6'b010101;  5'd11: return 6'b110100;
      5'd12: return 6'b001101;  5'd13: return 6'b101100;
      5'd14: return 6'b011100;  5'd15: return 6'b010111;
      5'd16: return 6'b011011;  5'd17: return 6'b100011;
      5'd18: return 6'b010011;  5'd19: return 6'b110010;
      5'd20: return 6'b001011;  5'd21: return 6'b101010;
      5'd22: return 6'b011010;  5'd23: return 6'b111010;
      5'd24: return 6'b110011;  5'd25: return 6'b100110;
      5'd26: return 6'b010110;  5'd27: return 6'b110110;
      5'd28: return 6'b001110;  5'd29: return 6'b101110;
      5'd30: return 6'b011110;  default: return 6'b101011;
    endcase
  endfunction

  // 3b/4b data RD- form (primary D.x.7), fghj packed MSB-first
  function automatic logic [3:0] enc4d_rdn(input logic [2:0] y);
    case (y)
      3'd0: return 4'b1011;  3'd1: return 4'b1001;
      3'd2: return 4'b0101;  3'd3: return 4'b1100;
      3'd4: return 4'b1101;  3'd5: return 4'b1010;
      3'd6: return 4'b0110;  default: return 4'b1110;
    endcase
  endfunction

  // 3b/4b control RD- form, fghj packed MSB-first
  function automatic logic [3:0] enc4k_rdn(input logic [2:0] y);
    case (y)
      3'd0: return 4'b1011;  3'd1: return 4'b0110;
      3'd2: return 4'b1010;  3'd3: return 4'b1100;
      3'd4: return 4'b1101;  3'd5: return 4'b0101;
      3'd6: return 4'b1001;  default: return 4'b0111;
    endcase
  endfunction

endpackage

// File: rtl/lvds_8b10b_encoder_if.sv
// Byte-side valid/ready channel into the 8b/10b encoder.
interface lvds_8b10b_encoder_if;
  import lvds_8b10b_pkg::*;

  logic              s_valid;
  logic              s_ready;
  logic [BYTE_W-1:0] s_data;
  logic              s_k;

  modport master (output s_valid, output s_data, output s_k, input s_ready);
  modport slave  (input s_valid, input s_data, input s_k, output s_ready);
endinterface

// File: rtl/enc_8b10b_core.sv
// Combinational Widmer-Franaszek 8b/10b encoder with running-disparity in/out.
// Illegal control requests are replaced by K28.5 and flagged.
module enc_8b10b_core
  import lvds_8b10b_pkg::*;
(
  input  logic [BYTE_W-1:0] data,
  input  logic              k,
  input  logic              rd_in,
  output logic [SYM_W-1:0]  code,
  output logic              rd_out,
  output logic              k_illegal
);

  logic [4:0] x;
  logic [2:0] y;
  logic       k28;
  logic       alt7;
  logic       rd_mid;
  logic [5:0] six_n;
  logic [5:0] six;
  logic [3:0] four_n;
  logic [3:0] four;

  // Encode 6b then 4b sub-blocks, each chained on the disparity left by the previous one
  always_comb begin
    k_illegal = k & ~k_legal(data);
    x         = k_illegal ? 5'd28 : data[4:0];
    y         = k_illegal ? 3'd5  : data[7:5];
    k28       = k & (x == 5'd28);

    six_n = k28 ? 6'b001111 : enc6_rdn(x);
    six   = (rd_in && (($countones(six_n) != 3) || (!k28 && (x == 5'd7)))) ? ~six_n : six_n;
    rd_mid = rd_in ^ ($countones(six) != 3);

    // D.x.A7 avoids a run of five inside the symbol
    alt7 = rd_mid ? ((x == 5'd11) || (x == 5'd13) || (x == 5'd14))
                  : ((x == 5'd17) || (x == 5'd18) || (x == 5'd20));

    if (k) begin
      four_n = enc4k_rdn(y);
    end else if ((y == 3'd7) && alt7) begin
      four_n = 4'b0111;
    end else begin
      four_n = enc4d_rdn(y);
    end
    four = (rd_mid && (k || ($countones(four_n) != 2) || (y == 3'd3) || (y == 3'd7)))
           ? ~four_n : four_n;
    rd_out = rd_mid ^ ($countones(four) != 2);

    code        = '0;
    code[BIT_A] = six[5];
    code[BIT_B] = six[4];
    code[BIT_C] = six[3];
    code[BIT_D] = six[2];
    code[BIT_E] = six[1];
    code[BIT_I] = six[0];
    code[BIT_F] = four[3];
    code[BIT_G] = four[2];
    code[BIT_H] = four[1];
    code[BIT_J] = four[0];
  end

endmodule

// File: rtl/lvds_8b10b_encoder.sv
// Registered 8b/10b transmit encoder: byte handshake, idle fill, RD tracking.
// Optional periodic K28.5 insertion is enabled by defining ENC_COMMA_INSERT_EN.
module lvds_8b10b_encoder
  import lvds_8b10b_pkg::*;
#(
  parameter int unsigned COMMA_PERIOD = 256,
  parameter logic [7:0]  IDLE_CHAR    = K28_5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  lvds_8b10b_encoder_if.slave  s_if,
  output logic [SYM_W-1:0]     m_data,
  output logic                 rd,
  output logic                 k_err
);

  logic             comma_due_c;
  enc_byte_t        src_c;
  logic [SYM_W-1:0] code_c;
  logic             rd_next_c;
  logic             k_illegal_c;

  logic [SYM_W-1:0] m_data_q, m_data_d;
  logic             rd_q, rd_d;
  logic             k_err_q, k_err_d;

`ifdef ENC_COMMA_INSERT_EN
  localparam int unsigned CNT_W = $clog2(COMMA_PERIOD);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             is_comma_c;

  assign comma_due_c = (cnt_q == CNT_W'(COMMA_PERIOD - 1));
  assign is_comma_c  = (code_c == K28_5_RDN) || (code_c == K28_5_RDP);

  // Symbols since the last K28.5 on the line
  always_comb begin
    cnt_d = cnt_q;
    if (en) begin
      cnt_d = is_comma_c ? '0 : cnt_q + CNT_W'(1);
    end
  end

  // Comma counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  logic unused_period;

  assign comma_due_c   = 1'b0;
  assign unused_period = ^COMMA_PERIOD;
`endif

  assign s_if.s_ready = en & ~comma_due_c;

  // Source select: forced comma, then offered byte, then idle
  always_comb begin
    src_c = '{k: 1'b1, data: IDLE_CHAR};
    if (comma_due_c) begin
      src_c = '{k: 1'b1, data: K28_5};
    end else if (s_if.s_valid) begin
      src_c = '{k: s_if.s_k, data: s_if.s_data};
    end
  end

  enc_8b10b_core u_core (
    .data      (src_c.data),
    .k         (src_c.k),
    .rd_in     (rd_q),
    .code      (code_c),
    .rd_out    (rd_next_c),
    .k_illegal (k_illegal_c)
  );

  // Symbol, disparity and error flag advance only on the word strobe
  always_comb begin
    m_data_d = m_data_q;
    rd_d     = rd_q;
    k_err_d  = k_err_q;
    if (en) begin
      m_data_d = code_c;
      rd_d     = rd_next_c;
      k_err_d  = k_illegal_c;
    end
  end

  // Output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_data_q <= K28_5_RDP;
      rd_q     <= 1'b0;
      k_err_q  <= 1'b0;
    end else begin
      m_data_q <= m_data_d;
      rd_q     <= rd_d;
      k_err_q  <= k_err_d;
    end
  end

  assign m_data = m_data_q;
  assign rd     = rd_q;
  assign k_err  = k_err_q;

endmodule

// File: tb/tb_lvds_8b10b_encoder.sv
// Self-checking bench for lvds_8b10b_encoder: directed table, held-valid run, random vs table model.
module tb_lvds_8b10b_encoder;

  localparam int unsigned PERIOD = 4;
  localparam logic [7:0]  IDLE   = 8'hBC;

  // Full code tables (abcdei / fghj strings, MSB = first transmitted bit), RD- and RD+ columns
  localparam logic [5:0] D6N [32] = '{
    6'b100111, 6'b011101, 6'b101101, 6'b110001, 6'b110101, 6'b101001, 6'b011001, 6'b111000,
    6'b111001, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b010111,
    6'b011011, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b111010,
    6'b110011, 6'b100110, 6'b010110, 6'b110110, 6'b001110, 6'b101110, 6'b011110, 6'b101011};
  localparam logic [5:0] D6P [32] = '{
    6'b011000, 6'b100010, 6'b010010, 6'b110001, 6'b001010, 6'b101001, 6'b011001, 6'b000111,
    6'b000110, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b101000,
    6'b100100, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b000101,
    6'b001100, 6'b100110, 6'b010110, 6'b001001, 6'b001110, 6'b010001, 6'b100001, 6'b010100};
  localparam logic [3:0] D4N [8] = '{4'b1011, 4'b1001, 4'b0101, 4'b1100, 4'b1101, 4'b1010, 4'b0110, 4'b1110};
  localparam logic [3:0] D4P [8] = '{4'b0100, 4'b1001, 4'b0101, 4'b0011, 4'b0010, 4'b1010, 4'b0110, 4'b0001};
  localparam logic [3:0] K4N [8] = '{4'b1011, 4'b0110, 4'b1010, 4'b1100, 4'b1101, 4'b0101, 4'b1001, 4'b0111};
  localparam logic [3:0] K4P [8] = '{4'b0100, 4'b1001, 4'b0101, 4'b0011, 4'b0010, 4'b1010, 4'b0110, 4'b1000};
  localparam logic [7:0] KLEGAL [12] = '{8'h1C, 8'h3C, 8'h5C, 8'h7C, 8'h9C, 8'hBC,
                                         8'hDC, 8'hFC, 8'hF7, 8'hFB, 8'hFD, 8'hFE};

  typedef struct {
    logic       en;
    logic       v;
    logic [7:0] d;
    logic       k;
    logic [9:0] m;
    logic       rd;
    logic       kerr;
    logic       rdy;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [9:0] m_data;
  logic       rd;
  logic       k_err;

  lvds_8b10b_encoder_if sif ();

  lvds_8b10b_encoder #(.COMMA_PERIOD(PERIOD), .IDLE_CHAR(IDLE)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (en),
    .s_if   (sif),
    .m_data (m_data),
    .rd     (rd),
    .k_err  (k_err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int acc_cnt = 0;
  int exp_acc = 0;
  int m_cnt = 0;
  logic [9:0] exp_m;
  logic       exp_rd;
  logic       exp_kerr;
  logic       last_rdy;
  vec_t       tbl [15];

  // Count bytes the DUT actually takes
  always @(posedge clk) begin
    if (rst_n && sif.s_valid && sif.s_ready) acc_cnt <= acc_cnt + 1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference encoder straight from the code tables
  function automatic void enc_ref(input logic [7:0] b, input logic kf, input logic rdi,
                                  output logic [9:0] sym, output logic rdo, output logic ke);
    logic [4:0] x;
    logic [2:0] y;
    logic [5:0] s6;
    logic [3:0] s4;
    logic       r6;
    logic [9:0] seq;
    x  = b[4:0];
    y  = b[7:5];
    ke = 1'b0;
    if (kf && !(x == 5'd28 || (y == 3'd7 && (x == 5'd23 || x == 5'd27 || x == 5'd29 || x == 5'd30)))) begin
      ke = 1'b1;
      x  = 5'd28;
      y  = 3'd5;
    end
    if (kf && x == 5'd28) s6 = rdi ? 6'b110000 : 6'b001111;
    else                  s6 = rdi ? D6P[x] : D6N[x];
    r6 = ($countones(s6) == 3) ? rdi : ~rdi;
    if (kf) s4 = r6 ? K4P[y] : K4N[y];
    else if (y == 3'd7 && ((!r6 && (x == 5'd17 || x == 5'd18 || x == 5'd20)) ||
                           ( r6 && (x == 5'd11 || x == 5'd13 || x == 5'd14))))
      s4 = r6 ? 4'b1000 : 4'b0111;
    else s4 = r6 ? D4P[y] : D4N[y];
    seq = {s6, s4};
    for (int i = 0; i < 10; i++) sym[i] = seq[9-i];
    rdo = ($countones(seq) == 5) ? rdi : ~rdi;
  endfunction

  function automatic logic model_due();
`ifdef ENC_COMMA_INSERT_EN
    return (m_cnt == int'(PERIOD) - 1);
`else
    return 1'b0;
`endif
  endfunction

  task automatic emit(input logic [7:0] b, input logic kf);
    logic [9:0] sym;
    logic       r;
    logic       ke;
    enc_ref(b, kf, exp_rd, sym, r, ke);
    exp_m    = sym;
    exp_rd   = r;
    exp_kerr = ke;
    if (sym == 10'h17C || sym == 10'h283) m_cnt = 0;
    else m_cnt++;
  endtask

  // One word clock: drive after a falling edge, check ready, then outputs after the next falling edge
  task automatic cycle(input logic e, input logic v, input logic [7:0] b, input logic kf);
    logic due;
    en          = e;
    sif.s_valid = v;
    sif.s_data  = b;
    sif.s_k     = kf;
    due         = model_due();
    #1;
    last_rdy = sif.s_ready;
    chk("s_ready", 32'(sif.s_ready), 32'(e && !due));
    if (e) begin
      if (due) emit(8'hBC, 1'b1);
      else if (v) begin
        emit(b, kf);
        exp_acc++;
      end else emit(IDLE, 1'b1);
    end
    @(posedge clk);
    @(negedge clk);
    chk("m_data", 32'(m_data), 32'(exp_m));
    chk("rd", 32'(rd), 32'(exp_rd));
    chk("k_err", 32'(k_err), 32'(exp_kerr));
  endtask

  task automatic mid_reset();
    en          = 1'b0;
    sif.s_valid = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    chk("rst m_data", 32'(m_data), 32'h283);
    chk("rst rd", 32'(rd), 32'd0);
    chk("rst k_err", 32'(k_err), 32'd0);
    @(negedge clk);
    rst_n    = 1'b1;
    exp_m    = 10'h283;
    exp_rd   = 1'b0;
    exp_kerr = 1'b0;
    m_cnt    = 0;
  endtask

  initial begin
    int a0;
    tbl[0]  = '{1'b1, 1'b0, 8'h00, 1'b0, 10'h17C, 1'b1, 1'b0, 1'b1};
    tbl[1]  = '{1'b1, 1'b0, 8'h00, 1'b0, 10'h283, 1'b0, 1'b0, 1'b1};
    tbl[2]  = '{1'b1, 1'b1, 8'hB5, 1'b0, 10'h155, 1'b0, 1'b0, 1'b1};
    tbl[3]  = '{1'b1, 1'b1, 8'h00, 1'b0, 10'h0B9, 1'b0, 1'b0, 1'b1};
    tbl[4]  = '{1'b1, 1'b1, 8'h00, 1'b1, 10'h17C, 1'b1, 1'b1, 1'b1};
    tbl[5]  = '{1'b1, 1'b0, 8'h00, 1'b0, 10'h283, 1'b0, 1'b0, 1'b1};
    tbl[6]  = '{1'b0, 1'b1, 8'h3C, 1'b1, 10'h283, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 8'h3C, 1'b1, 10'h283, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, 8'h3C, 1'b1, 10'h283, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{1'b1, 1'b1, 8'h3C, 1'b1, 10'h27C, 1'b1, 1'b0, 1'b1};
    tbl[10] = '{1'b1, 1'b1, 8'hFF, 1'b1, 10'h283, 1'b0, 1'b1, 1'b1};
    tbl[11] = '{1'b0, 1'b0, 8'h00, 1'b0, 10'h283, 1'b0, 1'b1, 1'b0};
    tbl[12] = '{1'b1, 1'b1, 8'hF7, 1'b1, 10'h057, 1'b0, 1'b0, 1'b1};
    tbl[13] = '{1'b1, 1'b1, 8'hF1, 1'b0, 10'h3B1, 1'b1, 1'b0, 1'b1};
    tbl[14] = '{1'b1, 1'b1, 8'hEB, 1'b0, 10'h04B, 1'b0, 1'b0, 1'b1};

    rst_n       = 1'b1;
    en          = 1'b0;
    sif.s_valid = 1'b0;
    sif.s_data  = 8'h00;
    sif.s_k     = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("reset m_data", 32'(m_data), 32'h283);
    chk("reset rd", 32'(rd), 32'd0);
    chk("reset k_err", 32'(k_err), 32'd0);
    en = 1'b1;
    #1;
    chk("reset s_ready", 32'(sif.s_ready), 32'd1);
    en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n    = 1'b1;
    exp_m    = 10'h283;
    exp_rd   = 1'b0;
    exp_kerr = 1'b0;
    m_cnt    = 0;

    // Directed vectors with hand-derived symbols
    for (int i = 0; i < 15; i++) begin
      cycle(tbl[i].en, tbl[i].v, tbl[i].d, tbl[i].k);
      chk($sformatf("tbl%0d m_data", i), 32'(m_data), 32'(tbl[i].m));
      chk($sformatf("tbl%0d rd", i), 32'(rd), 32'(tbl[i].rd));
      chk($sformatf("tbl%0d k_err", i), 32'(k_err), 32'(tbl[i].kerr));
      chk($sformatf("tbl%0d s_ready", i), 32'(last_rdy), 32'(tbl[i].rdy));
    end
    chk("tbl bytes taken", 32'(acc_cnt), 32'd8);

    // Valid held high across twelve strobes from a clean reset
    mid_reset();
    a0 = acc_cnt;
    for (int i = 0; i < 12; i++) begin
      cycle(1'b1, 1'b1, 8'(i * 17 + 3), 1'b0);
`ifdef ENC_COMMA_INSERT_EN
      chk($sformatf("hold%0d s_ready", i), 32'(last_rdy), 32'((i % 4) != 3));
      if ((i % 4) == 3) chk($sformatf("hold%0d comma", i), 32'(m_data == 10'h17C || m_data == 10'h283), 32'd1);
`else
      chk($sformatf("hold%0d s_ready", i), 32'(last_rdy), 32'd1);
`endif
    end
`ifdef ENC_COMMA_INSERT_EN
    chk("hold bytes taken", 32'(acc_cnt - a0), 32'd9);
`else
    chk("hold bytes taken", 32'(acc_cnt - a0), 32'd12);
`endif

    // Random traffic against the table model, with a reset dropped in mid-stream
    for (int i = 0; i < 300; i++) begin
      logic       e;
      logic       v;
      logic       kf;
      logic [7:0] b;
      e  = ($urandom_range(0, 3) != 0);
      v  = ($urandom_range(0, 2) != 0);
      kf = ($urandom_range(0, 7) == 0);
      b  = 8'($urandom);
      if (kf && $urandom_range(0, 1) == 1) b = KLEGAL[$urandom_range(0, 11)];
      if (i == 150) begin
        cycle(1'b1, 1'b1, 8'h3C, 1'b1);
        mid_reset();
      end
      cycle(e, v, b, kf);
    end
    chk("total bytes taken", 32'(acc_cnt), 32'(exp_acc));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
